// File: rtl/mem_req_arbiter_pkg.sv
// mem_arb_pkg: shared types and sizing helpers for the memory request arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ISSUE, RESP)
//   req_bits()  : width of a requester index for a given requester count
//   cnt_bits()  : width of the hold counter for a given HOLD_CYCLES
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // A requester index is never narrower than one bit.
    function automatic int req_bits(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // The counter must hold HOLD_CYCLES-1; never narrower than one bit.
    function automatic int cnt_bits(input int hold_cycles);
        return (hold_cycles <= 1) ? 1 : $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: requester-side and cache-controller-side signals of the
// arbiter bundled together.
//   master modport : requesters and cache controller (drive req*, mem_rdata)
//   slave modport  : the arbiter (drives ack, resp_rdata, grant_id, busy, mem_*)
interface mem_req_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) ();
    import mem_arb_pkg::*;

    localparam int REQ_BITS = req_bits(NUM_REQ);

    // Requester side
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]         resp_rdata;
    logic [REQ_BITS-1:0]           grant_id;
    logic                          busy;

    // Cache controller side
    logic                          mem_rd;
    logic                          mem_wr;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic [DATA_WIDTH-1:0]         mem_rdata;

    modport master (
        output req, req_wr, req_addr, req_wdata, mem_rdata,
        input  ack, resp_rdata, grant_id, busy,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  req, req_wr, req_addr, req_wdata, mem_rdata,
        output ack, resp_rdata, grant_id, busy,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_req_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req_i    : request vector
//   last_i   : index of the previously granted requester
//   found_o  : at least one request is pending
//   winner_o : first pending requester searching last_i+1, last_i+2, ... mod NUM_REQ
// The request vector is rotated so that position 0 is last_i+1, the lowest set
// bit is located, and its position is rotated back to a requester index.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int REQ_BITS = req_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [REQ_BITS-1:0] last_i,
    output logic                found_o,
    output logic [REQ_BITS-1:0] winner_o
);

    // Modulo NUM_REQ for operands below 2*NUM_REQ.
    function automatic int wrap(input int k);
        return (k >= NUM_REQ) ? (k - NUM_REQ) : k;
    endfunction

    logic [NUM_REQ-1:0] rot;
    int                 pos;

    always_comb begin
        rot     = '0;
        found_o = 1'b0;
        pos     = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            rot[j] = req_i[wrap(int'(last_i) + 1 + j)];
        end
        // Scan downwards so the lowest set position is the one that sticks.
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found_o = 1'b1;
                pos     = j;
            end
        end
        winner_o = REQ_BITS'(wrap(int'(last_i) + 1 + pos));
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one cache_controller port among NUM_REQ requesters.
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of mem_req_arbiter_if
//           requester side  req/req_wr/req_addr/req_wdata in, ack/resp_rdata/
//                           grant_id/busy out
//           controller side mem_rd/mem_wr/mem_addr/mem_wdata out, mem_rdata in
// A round-robin winner is latched at grant, its command is driven for
// HOLD_CYCLES cycles, read data is captured on the last command edge and a
// one-cycle ack is returned to the winner.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_req_arbiter_if.slave bus
);

    localparam int REQ_BITS = req_bits(NUM_REQ);
    localparam int CNT_W    = cnt_bits(HOLD_CYCLES);

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_l_q, wr_l_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [REQ_BITS-1:0]   grant_q, grant_d;
    logic [REQ_BITS-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;

    logic                  found;
    logic [REQ_BITS-1:0]   winner;

    rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .REQ_BITS (REQ_BITS)
    ) u_picker (
        .req_i    (bus.req),
        .last_i   (last_q),
        .found_o  (found),
        .winner_o (winner)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_l_d   = wr_l_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        grant_d  = grant_q;
        last_d   = last_q;
        ack_d    = '0;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    // Payload is captured here; later requester changes are ignored.
                    wr_l_d   = bus.req_wr[winner];
                    addr_d   = bus.req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d  = bus.req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
                    grant_d  = winner;
                    last_d   = winner;
                    cnt_d    = CNT_W'(HOLD_CYCLES - 1);
                    // Command registers rise on the grant edge so they are
                    // high for every ISSUE cycle.
                    mem_rd_d = !bus.req_wr[winner];
                    mem_wr_d = bus.req_wr[winner];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_rd_d       = 1'b0;
                    mem_wr_d       = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    if (!wr_l_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                // Forces at least one IDLE cycle between grants.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_l_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            grant_q  <= '0;
            last_q   <= REQ_BITS'(NUM_REQ - 1);
            ack_q    <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_l_q   <= wr_l_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

endmodule
